// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: FIFO store buffer between the core data port and data
// memory. Stores retire into a DEPTH-entry circular buffer and drain to memory
// one per accepted handshake; loads forward from the youngest matching entry.
// Optional feature macro: DMEM_BSWAP_EN (byte-reverse load data and drained
// store data so memory holds hex-image byte order).
//
// Handshakes (valid/ready): on the memory side mem_we is valid and mem_wready
// is ready; the head entry transfers on the clk edge where both are high, and
// mem_waddr/mem_wdata hold steady while mem_we is high and mem_wready is low.
// On the core side data_we is valid and !stall is ready; a store is taken on
// the edge where data_we is high and stall is low, otherwise the core holds it.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_we,
  input  logic [AW-1:0]            data_waddr,
  input  logic [31:0]              data_wdata,
  input  logic                     data_re,
  input  logic [AW-1:0]            data_raddr,
  output logic [31:0]              data_rdata,
  output logic                     stall,
  output logic [AW-1:0]            mem_raddr,
  input  logic [31:0]              mem_rdata,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_waddr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_wready,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0]   entry_addr [DEPTH];
  logic [31:0]     entry_data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic hit;
  logic [31:0] fwd_data;
  logic [PW-1:0] idx;

  // Byte-address low bits are meaningless at word granularity.
  logic unused_low_bits;
  assign unused_low_bits = ^{data_waddr[1:0], data_raddr[1:0]};

  function automatic logic [31:0] order_bytes(input logic [31:0] d);
`ifdef DMEM_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop in the same cycle never frees a slot for a push: push looks at full only.
  assign push  = data_we && !full;
  assign pop   = !empty && mem_wready;
  assign stall = data_we && full;

  // Pointer, count and valid-bit state; synchronous active-low reset drops pending entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload; intentionally not reset, only valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= data_waddr[AW-1:2];
      entry_data[tail] <= data_wdata;
    end
  end

  // Youngest-match search: walk oldest to youngest so the last hit wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (entry_addr[idx] == data_raddr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = entry_data[idx];
      end
    end
  end

  assign data_rdata = data_re ? order_bytes(hit ? fwd_data : mem_rdata) : 32'h0;
  assign mem_raddr  = data_raddr;
  assign mem_we     = !empty;
  assign mem_waddr  = {entry_addr[head], 2'b00};
  assign mem_wdata  = order_bytes(entry_data[head]);
  assign sb_empty   = empty;
  assign sb_count   = count;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: scoreboard bench for dmem_store_buffer. Reference model
// is a plain queue of buffered stores; expected memory writes queue in exp_q
// and a monitor pops them whenever the DUT completes a memory write.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = AW - 2 + 32;

  logic            clk;
  logic            rst_n;
  logic            data_we;
  logic [AW-1:0]   data_waddr;
  logic [31:0]     data_wdata;
  logic            data_re;
  logic [AW-1:0]   data_raddr;
  logic [31:0]     data_rdata;
  logic            stall;
  logic [AW-1:0]   mem_raddr;
  logic [31:0]     mem_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic            mem_wready;
  logic            sb_empty;
  logic [CW-1:0]   sb_count;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered stores, oldest at index 0.
  logic [AW-3:0] model_a[$];
  logic [31:0]   model_d[$];
  // Expected memory writes in order: {word address, raw store data}.
  logic [W-1:0]  exp_q[$];

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_we(data_we), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .data_re(data_re), .data_raddr(data_raddr), .data_rdata(data_rdata),
    .stall(stall), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .sb_empty(sb_empty), .sb_count(sb_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bswap(input logic [31:0] d);
`ifdef DMEM_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic [31:0] mrd,
                      input logic wr);
    int n;
    logic [31:0] exp_rd;
    logic found;
    data_we    = we;
    data_waddr = wa;
    data_wdata = wd;
    data_re    = re;
    data_raddr = ra;
    mem_rdata  = mrd;
    mem_wready = wr;
    @(negedge clk);
    n = model_d.size();
    check("stall", 64'(stall), 64'(we && (n == DEPTH)));
    check("sb_count", 64'(sb_count), 64'(n));
    check("sb_empty", 64'(sb_empty), 64'(n == 0));
    check("mem_we", 64'(mem_we), 64'(n != 0));
    check("mem_raddr", 64'(mem_raddr), 64'(ra));
    if (n != 0) begin
      check("head_waddr", 64'(mem_waddr), 64'({model_a[0], 2'b00}));
      check("head_wdata", 64'(mem_wdata), 64'(bswap(model_d[0])));
    end
    found  = 1'b0;
    exp_rd = mrd;
    for (int i = n - 1; i >= 0; i--) begin
      if (!found && model_a[i] == ra[AW-1:2]) begin
        found  = 1'b1;
        exp_rd = model_d[i];
      end
    end
    check("data_rdata", 64'(data_rdata), re ? 64'(bswap(exp_rd)) : 64'h0);
    @(posedge clk);
    if (wr && n > 0) begin
      void'(model_a.pop_front());
      void'(model_d.pop_front());
    end
    if (we && n < DEPTH) begin
      model_a.push_back(wa[AW-1:2]);
      model_d.push_back(wd);
      exp_q.push_back({wa[AW-1:2], wd});
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    data_we    = 1'b0;
    data_re    = 1'b0;
    mem_wready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_a.delete();
    model_d.delete();
    exp_q.delete();
  endtask

  task automatic idle(input logic wr);
    step(1'b0, '0, '0, 1'b0, '0, 32'h0, wr);
  endtask

  // Scoreboard monitor: every completed memory write must match the oldest expected one.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && mem_we && mem_wready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_unexpected actual_addr=%h actual_data=%h required=none", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_waddr), 64'({e[W-1:32], 2'b00}));
        check("wr_data", 64'(mem_wdata), 64'(bswap(e[31:0])));
      end
    end
  end

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    data_we    = 1'b0;
    data_waddr = '0;
    data_wdata = '0;
    data_re    = 1'b0;
    data_raddr = '0;
    mem_rdata  = '0;
    mem_wready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and idle.
    idle(1'b0);

    // Single store, held, then drained.
    step(1'b1, 32'h100, 32'h11111111, 1'b0, '0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Forwarding of the youngest match; miss goes to memory.
    step(1'b1, 32'h200, 32'hAAAA0001, 1'b0, '0, 32'h0, 1'b0);
    step(1'b1, 32'h200, 32'hAAAA0002, 1'b0, '0, 32'h0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0);
    step(1'b0, '0, '0, 1'b1, 32'h204, 32'hDEADBEEF, 1'b0);
    // Load hitting the popping head still forwards.
    step(1'b0, '0, '0, 1'b1, 32'h200, 32'h0BAD0BAD, 1'b1);
    repeat (DEPTH + 1) idle(1'b1);

    // Full: 5th store stalls, a same-cycle pop does not unblock it.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h500 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0, '0, 32'h0, 1'b0);
    step(1'b1, 32'h510, 32'h5000_0004, 1'b0, '0, 32'h0, 1'b0);
    step(1'b1, 32'h510, 32'h5000_0004, 1'b0, '0, 32'h0, 1'b1);
    step(1'b1, 32'h510, 32'h5000_0004, 1'b0, '0, 32'h0, 1'b0);
    idle(1'b0);
    repeat (DEPTH + 1) idle(1'b1);

    // Wrap-around with continuous push and pop.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h300 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h300 + 32'(4 * i), 32'h1234_5678, 1'b1);
    repeat (DEPTH + 1) idle(1'b1);

    // Reset mid-drain discards pending entries.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h600 + 32'(4 * i), 32'h6000_0000 + 32'(i), 1'b0, '0, 32'h0, 1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b0);

    // Randomized traffic over a small address window to provoke hits and overwrites.
    for (int c = 0; c < 400; c++) begin
      step(1'(($urandom_range(0, 99) < 60) ? 1 : 0),
           32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
           $urandom,
           1'($urandom_range(0, 1)),
           32'h400 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3)),
           $urandom,
           1'(($urandom_range(0, 99) < 45) ? 1 : 0));
    end
    repeat (DEPTH + 2) idle(1'b1);

    // Every accepted store must have reached memory.
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
